// File: rtl/bspi_pkg.sv
// Shared definitions for the boot-SPI slave bridge:
// command codes, FSM states and status word layout.
package bspi_pkg;

    localparam logic [1:0] CMD_NOP    = 2'h0;
    localparam logic [1:0] CMD_READ   = 2'h1;
    localparam logic [1:0] CMD_WRITE  = 2'h2;
    localparam logic [1:0] CMD_STATUS = 2'h3;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        DUMMY,
        RDATA,
        IGNORE
    } state_t;

    localparam int STAT_OVR    = 0;
    localparam int STAT_URN    = 1;
    localparam int STAT_FRM_LO = 8;

    // 16-bit status layout before zero-extension to the data width
    function automatic logic [15:0] status_word(
        input logic [7:0] frames,
        input logic       urn,
        input logic       ovr
    );
        logic [15:0] s;
        s = '0;
        s[STAT_FRM_LO +: 8] = frames;
        s[STAT_URN]         = urn;
        s[STAT_OVR]         = ovr;
        return s;
    endfunction

endpackage

// File: rtl/bspi_sync_edge.sv
// Synchroniser for the SPI pins into the clk domain with
// edge pulses on the synchronised sck and cs_n.
module bspi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scs,
    input  logic sck,
    input  logic sdi,
    output logic scs_s,
    output logic sdi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic scs_rise,
    output logic scs_fall
);

    logic [SYNC_STAGES-1:0] scs_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sck_prev;
    logic                   scs_prev;

    // cs_n resets as "selected" so a frame already in flight at reset
    // release is not mistaken for a fresh falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scs_q    <= '0;
            sck_q    <= '1;
            sdi_q    <= '0;
            sck_prev <= 1'b1;
            scs_prev <= 1'b0;
        end else begin
            scs_q    <= {scs_q[SYNC_STAGES-2:0], scs};
            sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
            sdi_q    <= {sdi_q[SYNC_STAGES-2:0], sdi};
            sck_prev <= sck_q[SYNC_STAGES-1];
            scs_prev <= scs_q[SYNC_STAGES-1];
        end
    end

    assign scs_s    = scs_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_q[SYNC_STAGES-1];
    assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_prev;
    assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_prev;
    assign scs_rise = scs_q[SYNC_STAGES-1] & ~scs_prev;
    assign scs_fall = ~scs_q[SYNC_STAGES-1] & scs_prev;

endmodule

// File: rtl/bspi_bridge.sv
// Boot-SPI slave bridge: header decode, burst write/read into a
// boot memory port, MSB-first read-back and a status command.
module bspi_bridge
    import bspi_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int HDR_W       = 16,
    parameter int RD_DUMMY    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam int M1    = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int MX    = (M1 > RD_DUMMY) ? M1 : RD_DUMMY;
    localparam int CNT_W = $clog2(MX + 1);

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DAT_DONE = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] DMY_LAST = CNT_W'(RD_DUMMY - 1);

    logic scs_s;
    logic sdi_s;
    logic sck_rise;
    logic sck_fall;
    logic scs_rise;
    logic scs_fall;

    bspi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scs      (spi_cs_n),
        .sck      (spi_sck),
        .sdi      (spi_sdi),
        .scs_s    (scs_s),
        .sdi_s    (sdi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .scs_rise (scs_rise),
        .scs_fall (scs_fall)
    );

    state_t             state;
    logic [1:0]         fcmd;
    logic [HDR_W-2:0]   hdr_sr;
    logic [DATA_W-2:0]  wsr;
    logic [DATA_W-1:0]  txsr;
    logic [DATA_W-1:0]  rd_buf;
    logic [CNT_W-1:0]   bit_cnt;
    logic [ADDR_W-1:0]  addr;
    logic               rd_want;
    logic               rd_out;
    logic               rd_valid;
    logic               ovr;
    logic               urn;
    logic [7:0]         frames;
    logic               sdo;

    logic [HDR_W-1:0]   hdr_next;
    logic [DATA_W-1:0]  wsr_next;
    logic [1:0]         hdr_cmd;
    logic [ADDR_W-1:0]  hdr_addr;
    logic [15:0]        stat16;
    logic [DATA_W-1:0]  stat_word;
    logic               mem_pend;
    logic               rd_hit;
    logic [DATA_W-1:0]  ld_word;
    logic               ld_miss;
    logic               frame_end;

    assign hdr_next  = {hdr_sr, sdi_s};
    assign wsr_next  = {wsr, sdi_s};
    assign hdr_cmd   = hdr_next[HDR_W-1 -: 2];
    assign hdr_addr  = hdr_next[ADDR_W-1:0];
    assign stat16    = status_word(frames, urn, ovr);
    assign mem_pend  = mem_req & ~mem_ready;
    assign rd_hit    = mem_req & ~mem_we & mem_ready & rd_out;
    assign ld_miss   = ~rd_valid & ~rd_hit;
    assign frame_end = (state != IDLE) & (scs_rise | ~cfg_en);

    // Status word zero-extended (or truncated) to the data width
    always_comb begin
        stat_word = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < DATA_W) stat_word[i] = stat16[i];
        end
    end

    // Word handed to the tx shifter at a load point; all-ones on underrun
    always_comb begin
        ld_word = '1;
        if (rd_valid) ld_word = rd_buf;
        else if (rd_hit) ld_word = mem_rdata;
    end

    // Memory handshake, read issue and the frame FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fcmd      <= CMD_NOP;
            hdr_sr    <= '0;
            wsr       <= '0;
            txsr      <= '0;
            rd_buf    <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            rd_want   <= 1'b0;
            rd_out    <= 1'b0;
            rd_valid  <= 1'b0;
            ovr       <= 1'b0;
            urn       <= 1'b0;
            frames    <= '0;
            sdo       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (mem_req && mem_ready) begin
                mem_req <= 1'b0;
                if (!mem_we && rd_out) begin
                    rd_buf   <= mem_rdata;
                    rd_valid <= 1'b1;
                    rd_out   <= 1'b0;
                end
            end

            if (rd_want && !mem_req) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= addr;
                rd_want  <= 1'b0;
                rd_out   <= 1'b1;
            end

            if (frame_end) begin
                state    <= IDLE;
                sdo      <= 1'b0;
                rd_want  <= 1'b0;
                rd_out   <= 1'b0;
                rd_valid <= 1'b0;
                fcmd     <= CMD_NOP;
                if (fcmd == CMD_READ || fcmd == CMD_WRITE)
                    frames <= frames + 8'd1;
                if (fcmd == CMD_STATUS) begin
                    ovr <= 1'b0;
                    urn <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (scs_fall && cfg_en) begin
                            state   <= HDR;
                            bit_cnt <= '0;
                        end
                    end
                    HDR: begin
                        if (sck_rise) begin
                            hdr_sr  <= hdr_next[HDR_W-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == HDR_LAST) begin
                                bit_cnt <= '0;
                                fcmd    <= hdr_cmd;
                                unique case (hdr_cmd)
                                    CMD_WRITE: begin
                                        addr  <= hdr_addr;
                                        state <= WDATA;
                                    end
                                    CMD_READ: begin
                                        addr    <= hdr_addr;
                                        rd_want <= 1'b1;
                                        state   <= DUMMY;
                                    end
                                    CMD_STATUS: begin
                                        txsr  <= stat_word;
                                        state <= RDATA;
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    WDATA: begin
                        if (sck_rise) begin
                            wsr     <= wsr_next[DATA_W-2:0];
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == DAT_LAST) begin
                                bit_cnt <= '0;
                                addr    <= addr + 1'b1;
                                if (mem_pend) begin
                                    ovr <= 1'b1;
                                end else begin
                                    mem_req   <= 1'b1;
                                    mem_we    <= 1'b1;
                                    mem_addr  <= addr;
                                    mem_wdata <= wsr_next;
                                end
                            end
                        end
                    end
                    DUMMY: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == DMY_LAST) begin
                                bit_cnt  <= '0;
                                txsr     <= ld_word;
                                rd_valid <= 1'b0;
                                rd_out   <= 1'b0;
                                if (ld_miss) urn <= 1'b1;
                                state    <= RDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (sck_fall && bit_cnt != DAT_DONE) begin
                            sdo     <= txsr[DATA_W-1];
                            txsr    <= {txsr[DATA_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == DAT_LAST &&
                                fcmd == CMD_READ) begin
                                addr    <= addr + 1'b1;
                                rd_want <= 1'b1;
                            end
                        end else if (sck_rise && bit_cnt == DAT_DONE) begin
                            bit_cnt <= '0;
                            if (fcmd == CMD_STATUS) begin
                                txsr <= stat_word;
                            end else begin
                                txsr     <= ld_word;
                                rd_valid <= 1'b0;
                                rd_out   <= 1'b0;
                                if (ld_miss) urn <= 1'b1;
                            end
                        end
                    end
                    IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign spi_sdo    = sdo;
    assign spi_sdo_oe = ((state == DUMMY) | (state == RDATA)) & ~scs_s;
    assign busy       = (state != IDLE) | mem_req;
    assign err        = ovr | urn;

endmodule

// File: tb/tb_bspi_bridge.sv
// Directed self-checking bench for bspi_bridge: vector table of
// single writes plus burst, read, overrun, status, abort, reset cases.
module tb_bspi_bridge;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo;
    logic        spi_sdo_oe;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    int   lat_cfg = 0;
    logic hold = 1'b0;
    int   lat = 0;
    int   oe_cnt = 0;

    logic [10:0] wa[$];
    logic [31:0] wd[$];
    logic        ww[$];

    bspi_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_en     (cfg_en),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .spi_sdo_oe (spi_sdo_oe),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && !mem_ready) lat <= lat + 1;
        else lat <= 0;
    end

    assign mem_ready = !hold && mem_req && (lat >= lat_cfg);
    assign mem_rdata = 32'(mem_addr) * 32'h1111;

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ready) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            ww.push_back(mem_we);
        end
        if (spi_sdo_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic frame(input int n, input logic [255:0] tx,
                         input bit keep, output logic [255:0] rx);
        rx = '0;
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            spi_sck = 1'b0;
            spi_sdi = tx[n-1-i];
            repeat (H) @(negedge clk);
            spi_sck = 1'b1;
            rx = {rx[254:0], spi_sdo};
            repeat (H) @(negedge clk);
        end
        if (!keep) begin
            spi_cs_n = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [15:0] hdr;
        logic [31:0] data;
        logic [10:0] addr;
    } wvec_t;

    wvec_t       vt[4];
    logic [255:0] tx;
    logic [255:0] rx;
    int          base;
    int          oe0;
    int          frames_exp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{16'h8005, 32'h0C800A13, 11'h005};
        vt[1] = '{16'h8000, 32'hDEADBEEF, 11'h000};
        vt[2] = '{16'h87FF, 32'h00000001, 11'h7FF};
        vt[3] = '{16'hB123, 32'hA5A55A5A, 11'h123};
        frames_exp = 0;

        repeat (3) @(negedge clk);
        chk("rst_outs", {59'd0, mem_req, busy, err, spi_sdo, spi_sdo_oe},
            64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            base = wa.size();
            tx = '0;
            tx[47:0] = {vt[v].hdr, vt[v].data};
            frame(48, tx, 1'b0, rx);
            wait_idle("wr_busy");
            chk("wr_count", 64'(wa.size() - base), 64'd1);
            if (wa.size() > base) begin
                chk("wr_addr", 64'(wa[base]), 64'(vt[v].addr));
                chk("wr_data", 64'(wd[base]), 64'(vt[v].data));
                chk("wr_we", 64'(ww[base]), 64'd1);
            end
            chk("wr_err", 64'(err), 64'd0);
            frames_exp++;
        end

        base = wa.size();
        tx = '0;
        tx[111:0] = {16'h87FF, 32'h11111111, 32'h22222222, 32'h33333333};
        frame(112, tx, 1'b0, rx);
        wait_idle("bw_busy");
        chk("bw_count", 64'(wa.size() - base), 64'd3);
        if (wa.size() >= base + 3) begin
            chk("bw_a0", 64'(wa[base]), 64'h7FF);
            chk("bw_a1", 64'(wa[base+1]), 64'h000);
            chk("bw_a2", 64'(wa[base+2]), 64'h001);
            chk("bw_d2", 64'(wd[base+2]), 64'h33333333);
        end
        frames_exp++;

        lat_cfg = 3;
        base = wa.size();
        oe0 = oe_cnt;
        tx = '0;
        tx[87:0] = {16'h4002, 72'h0};
        frame(88, tx, 1'b0, rx);
        wait_idle("rd_busy");
        chk("rd_data", rx[63:0], {32'h00002222, 32'h00003333});
        chk("rd_err", 64'(err), 64'd0);
        chk("rd_oe", 64'(oe_cnt > oe0), 64'd1);
        if (wa.size() > base) begin
            chk("rd_a0", 64'(wa[base]), 64'h002);
            chk("rd_we", 64'(ww[base]), 64'd0);
        end
        lat_cfg = 0;
        frames_exp++;

        hold = 1'b1;
        base = wa.size();
        tx = '0;
        tx[79:0] = {16'h8010, 32'hCAFEF00D, 32'h0BADBEEF};
        frame(80, tx, 1'b0, rx);
        chk("ovr_req", 64'(mem_req), 64'd1);
        chk("ovr_wd", 64'(mem_wdata), 64'hCAFEF00D);
        chk("ovr_err", 64'(err), 64'd1);
        chk("ovr_busy", 64'(busy), 64'd1);
        hold = 1'b0;
        wait_idle("ovr_idle");
        chk("ovr_count", 64'(wa.size() - base), 64'd1);
        if (wa.size() > base)
            chk("ovr_addr", 64'(wa[base]), 64'h010);
        frames_exp++;

        tx = '0;
        tx[47:0] = {16'hC000, 32'h0};
        frame(48, tx, 1'b0, rx);
        chk("st_flags", 64'(rx[1:0]), 64'd1);
        chk("st_frames", 64'(rx[15:8]), 64'(frames_exp));
        chk("st_upper", 64'(rx[31:16]), 64'd0);
        chk("st_errclr", 64'(err), 64'd0);

        base = wa.size();
        tx = '0;
        tx[35:0] = {16'h8005, 20'hABCDE};
        frame(36, tx, 1'b0, rx);
        wait_idle("ab_busy");
        chk("ab_count", 64'(wa.size() - base), 64'd0);

        cfg_en = 1'b0;
        base = wa.size();
        oe0 = oe_cnt;
        tx = '0;
        tx[47:0] = {16'h8005, 32'h12345678};
        frame(48, tx, 1'b0, rx);
        tx = '0;
        tx[87:0] = {16'h4002, 72'h0};
        frame(88, tx, 1'b0, rx);
        chk("cfg_count", 64'(wa.size() - base), 64'd0);
        chk("cfg_oe", 64'(oe_cnt - oe0), 64'd0);
        chk("cfg_busy", 64'(busy), 64'd0);
        cfg_en = 1'b1;

        tx = '0;
        tx[33:0] = {16'h4002, 18'h0};
        frame(34, tx, 1'b1, rx);
        repeat (2) @(negedge clk);
        chk("mr_oe", 64'(spi_sdo_oe), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_outs",
            {59'd0, mem_req, busy, err, spi_sdo, spi_sdo_oe}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        base = wa.size();
        tx = '0;
        tx[47:0] = {16'h8000, 32'h600DF00D};
        frame(48, tx, 1'b0, rx);
        wait_idle("mr_busy");
        chk("mr_count", 64'(wa.size() - base), 64'd1);
        if (wa.size() > base) begin
            chk("mr_addr", 64'(wa[base]), 64'h000);
            chk("mr_data", 64'(wd[base]), 64'h600DF00D);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bspi_bridge.md
Name: bspi_bridge

Overview:
Parametrised boot-SPI slave bridge: the successor to the fixed write-only boot SPI. It oversamples io_scs/io_sck/io_sdi in the clk domain and decodes a header of {cmd, reserved, addr}. It performs single or burst (auto-increment) word writes and reads into a boot memory port over a req/ready handshake, and adds MSB-first read-back on sdo plus a status command. It sits between the SoC boot pins (gated by io_bcf) and the IMEM/DMEM boot-write mux.

Parameters:
ADDR_W, 11, word address width (HDR_W >= ADDR_W+2 required)
DATA_W, 32, data word width in bits (8..64)
HDR_W, 16, header length in bits; cmd = hdr[HDR_W-1:HDR_W-2], addr = hdr[ADDR_W-1:0], other bits ignored
RD_DUMMY, 8, dummy sck cycles between header and first read data bit
SYNC_STAGES, 2, synchroniser depth on scs/sck/sdi (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_en  in  1  boot-config enable (io_bcf); frames ignored while 0
spi_cs_n  in  1  chip select, active low
spi_sck  in  1  SPI clock, idle high; sampled on rising, driven on falling edge
spi_sdi  in  1  serial data in, MSB first
spi_sdo  out  1  serial data out, MSB first
spi_sdo_oe  out  1  sdo output enable
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_ready  in  1  accept; for reads mem_rdata is valid in the same cycle
mem_rdata  in  DATA_W  read data
busy  out  1  frame in progress or memory transaction pending
err  out  1  sticky error (overrun | underrun)

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; every output 0; addr, shift registers, counters and sticky flags cleared. Reset may occur mid-frame or mid-transaction: the bridge drops everything, and the next frame starts cleanly after rst_n=1 and a cs_n high->low edge.
- Sync: scs/sck/sdi pass through SYNC_STAGES flops; edges are detected on the synchronised sck. Required: sck high and low phases each >= SYNC_STAGES+2 clk.
- FSM: IDLE -> HDR on synchronised cs_n falling edge with cfg_en=1. HDR shifts HDR_W bits, then decodes cmd:
  2'h2 WRITE -> WDATA
  2'h1 READ -> issue read of addr, enter DUMMY
  2'h3 STATUS -> load status word, enter RDATA
  2'h0 NOP -> IGNORE until cs_n rises
- WDATA: after every DATA_W bits, capture the word, raise mem_req/mem_we=1 with the current addr, then addr <= addr+1 mod 2^ADDR_W (wrap, no error). If the previous request is still pending when a new word completes: drop the new word, set ovr sticky.
- DUMMY: count RD_DUMMY rising edges; the prefetched word loads into the tx shifter at the last dummy rising edge. If mem_ready has not arrived by then: shift all-ones, set urn sticky. Then enter RDATA.
- RDATA: sdo changes on synchronised sck falling edge; the MSB is presented after the load. When bit 0 of a word is presented, prefetch addr+1 (burst). Boundary handling at the word boundary follows the DUMMY underrun rule.
- spi_sdo_oe=1 only in DUMMY/RDATA while cs_n=0.
- Status word (zero-extended to DATA_W): {frames[7:0], 6'b0, urn, ovr}. frames counts completed WRITE/READ frames, mod 256.
- Frame end (synchronised cs_n rising, any state): go to IDLE and discard any partial word. An outstanding mem_req stays asserted until mem_ready, and busy stays high until then. A STATUS frame clears ovr/urn at frame end. A new frame starting while the request is pending is allowed (busy=1).
- cfg_en falling mid-frame: treated as frame end. cs_n activity with cfg_en=0: no state change.
- err = ovr | urn. busy = (state != IDLE) | mem_req.
- Latency: write mem_req is asserted <= 2 clk after the synchronised rising edge carrying the word's last bit.

Decomposition:
- Shared package bspi_pkg: CMD_NOP/CMD_READ/CMD_WRITE/CMD_STATUS localparams, FSM state encoding (IDLE, HDR, WDATA, DUMMY, RDATA, IGNORE), status bit indices.
- Sub-module: bspi_sync_edge (SYNC_STAGES-deep synchroniser for scs/sck/sdi with rise/fall pulse outputs). Everything else stays in bspi_bridge.

Test Plan:
- Single write: header 16'h8005, data 32'h0C800A13, mem_ready tied 1 -> one mem_req, we=1, addr=5, wdata=32'h0C800A13; err=0; busy drops after cs_n rise.
- Burst write at addr 11'h7FF with 3 words A,B,C -> writes at 7FF, 000, 001 in order (wrap).
- Burst read from addr 2, mem returns addr*16'h1111 with 3-clk ready latency, RD_DUMMY=8 -> sdo streams 32'h2222 then 32'h3333; urn=0.
- Overrun: mem_ready held 0 across two completed write words -> exactly one mem_req (first word), ovr=1, err=1. The following STATUS frame reads bit0=1, and err=0 after that frame's cs_n rise.
- Abort and gating: cs_n rises after 20 data bits -> no write. A frame with cfg_en=0 -> no mem_req, sdo_oe=0.
- Reset mid-burst-read: rst_n=0 for 1 clk while in RDATA -> all outputs 0 immediately; a subsequent single write to addr 0 completes normally.
